cond_logic: RTL

//  Conditional-execution stage directly downstream of the microprogrammed decoder.

---
 rtl/cond_pkg.sv | 34 +++
 rtl/cond_check.sv | 45 ++++
 rtl/cond_logic.sv | 119 +++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage.
//   cond_e   : the sixteen Instr[31:28] condition codes
//   FLG_*    : bit positions of N, Z, C, V inside the packed flag vector
//   COND_W / FLAG_W : field widths used by the stage and its sub-module
package cond_pkg;

  localparam int unsigned COND_W = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage : cond_pkg

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction with
// condition field cond_i executes against the flag vector flags_i.
//   cond_i  in  4  condition code (Instr[31:28])
//   flags_i in  4  {N,Z,C,V}
//   pass_o  out 1  1 = condition satisfied (combinational)
module cond_check
  import cond_pkg::*;
(
  input  logic [COND_W-1:0] cond_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLG_N];
  assign z = flags_i[FLG_Z];
  assign c = flags_i[FLG_C];
  assign v = flags_i[FLG_V];

  // Condition table; code F is treated as always, like AL.
  always_comb begin
    pass_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b1;
      default: pass_o = 1'b1;
    endcase
  end

endmodule : cond_check

// File: rtl/cond_logic.sv
// Conditional-execution stage behind the microprogrammed decoder.
// Holds NZCV, latches the condition result once per instruction in the
// decode cycle, gates the decoder enables into datapath strobes and counts
// executed vs squashed instructions.
//   clk, reset          clock / async active-low reset
//   Cond, ALUFlags      Instr[31:28], ALU {N,Z,C,V}
//   FlagW, PCS, NextPC, RegW, MemW, noRegW, IRWrite   decoder enables
//   clr_cnt             synchronous clear of both counters
//   PCWrite, RegWrite, MemWrite   gated strobes (combinational)
//   Flags, CondEx       architectural flags, latched condition (registered)
//   exec_cnt, squash_cnt          saturating instruction counters
module cond_logic
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COND_W-1:0] Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              NextPC,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              noRegW,
  input  logic              IRWrite,
  input  logic              clr_cnt,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [FLAG_W-1:0] Flags,
  output logic              CondEx,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              dec_q,     dec_d;
  logic              cond_ex_q, cond_ex_d;
  logic [FLAG_W-1:0] flags_q,   flags_d;
  logic [CNT_W-1:0]  exec_q,    exec_d;
  logic [CNT_W-1:0]  squash_q,  squash_d;
  logic              pass;

  // Evaluated against the registered flags only, never the live ALU flags.
  cond_check u_cond_check (
    .cond_i  (Cond),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  // Next-state: flag writes use the CondEx of the instruction in flight, so a
  // write coinciding with a decode is gated by the old result and the decode
  // sees the pre-update flags.
  always_comb begin
    dec_d     = IRWrite;
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    exec_d    = exec_q;
    squash_d  = squash_q;

    if (dec_q) begin
      cond_ex_d = pass;
    end

    if (FlagW[1] && cond_ex_q) begin
      flags_d[FLG_N] = ALUFlags[FLG_N];
      flags_d[FLG_Z] = ALUFlags[FLG_Z];
    end
    if (FlagW[0] && cond_ex_q) begin
      flags_d[FLG_C] = ALUFlags[FLG_C];
      flags_d[FLG_V] = ALUFlags[FLG_V];
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    if (clr_cnt) begin
      exec_d   = '0;
      squash_d = '0;
    end else if (dec_q) begin
      if (pass) begin
        if (exec_q != CNT_MAX) exec_d = exec_q + CNT_W'(1);
      end else begin
        if (squash_q != CNT_MAX) squash_d = squash_q + CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q     <= 1'b0;
      cond_ex_q <= 1'b0;
      flags_q   <= '0;
      exec_q    <= '0;
      squash_q  <= '0;
    end else begin
      dec_q     <= dec_d;
      cond_ex_q <= cond_ex_d;
      flags_q   <= flags_d;
      exec_q    <= exec_d;
      squash_q  <= squash_d;
    end
  end

  // Strobes are forced low while reset is held, even if NextPC is asserted.
  always_comb begin
    PCWrite  = reset & (NextPC | (PCS & cond_ex_q));
    RegWrite = reset & RegW & cond_ex_q & ~noRegW;
    MemWrite = reset & MemW & cond_ex_q;
  end

  assign Flags      = flags_q;
  assign CondEx     = cond_ex_q;
  assign exec_cnt   = exec_q;
  assign squash_cnt = squash_q;

endmodule : cond_logic
